// File: rtl/core_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// core_run_ctrl_if
// Groups the signals between the run/halt controller and its surroundings:
// the raw board keys, the breakpoint switch/address, the core's debug PC, and
// the controls/status the controller gives back.
//
//   key_rst, key_run, key_step : raw pushbuttons, active-low, asynchronous
//   sw_break_en                : breakpoint enable switch
//   break_addr[31:0]           : breakpoint PC
//   pc_addr[31:0]              : current PC from the core debug port
//   core_clk_en                : core advances on clk only when 1
//   core_rst                   : active-high synchronous core reset
//   ctrl_state[1:0]            : RESET=0, HALT=1, RUN=2, STEP=3
//   cycle_cnt[31:0]            : enabled core cycles outside RESET
//
// modport master : board/core side (drives keys, switch, PC)
// modport slave  : the controller
// ---------------------------------------------------------------------------
interface core_run_ctrl_if;
  logic        key_rst;
  logic        key_run;
  logic        key_step;
  logic        sw_break_en;
  logic [31:0] break_addr;
  logic [31:0] pc_addr;
  logic        core_clk_en;
  logic        core_rst;
  logic [1:0]  ctrl_state;
  logic [31:0] cycle_cnt;

  modport master (
    output key_rst, key_run, key_step, sw_break_en, break_addr, pc_addr,
    input  core_clk_en, core_rst, ctrl_state, cycle_cnt
  );

  modport slave (
    input  key_rst, key_run, key_step, sw_break_en, break_addr, pc_addr,
    output core_clk_en, core_rst, ctrl_state, cycle_cnt
  );
endinterface

// File: rtl/core_run_ctrl.sv
// ---------------------------------------------------------------------------
// core_run_ctrl
// Run/halt/single-step controller for the SiMPLE core. Debounces the three
// board keys, sequences the core reset, gates the core clock enable, halts on
// an optional PC breakpoint and counts enabled core cycles.
//
// Parameters:
//   DEBOUNCE_CYCLES : cycles a synced key level must differ from the accepted
//                     level before it is accepted
//   RST_CYCLES      : cycles core_rst is held in RESET (1..255)
// Ports:
//   clk  : board clock (also clocks the core)
//   rst  : asynchronous active-low reset of this block
//   bus  : core_run_ctrl_if.slave (keys, breakpoint, PC in; controls out)
// Build option:
//   CORE_RUN_CTRL_BREAKPOINT_EN : compiles in the PC breakpoint; without it
//   RUN only ends on a run or reset press.
// ---------------------------------------------------------------------------
module core_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RST_CYCLES      = 16
) (
  input  logic            clk,
  input  logic            rst,
  core_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HALT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  localparam int             DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]      RST_LAST = 8'(RST_CYCLES - 1);

  // Key index: 0 = reset, 1 = run, 2 = step
  logic [2:0]      w_key_raw;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      r_stable;
  logic [2:0]      r_press;
  logic [DB_W-1:0] r_db_cnt [3];

  state_t          r_state;
  logic [7:0]      r_rst_cnt;
  logic            r_core_rst;
  logic [31:0]     r_cycle_cnt;
  logic            w_bp_hit;
  logic            w_clk_en;
  logic            w_press_rst;
  logic            w_press_run;
  logic            w_press_step;

  assign w_key_raw    = {bus.key_step, bus.key_run, bus.key_rst};
  assign w_press_rst  = r_press[0];
  assign w_press_run  = r_press[1];
  assign w_press_step = r_press[2];

  // Key path: 2-FF synchronizer, then a counter of consecutive cycles in
  // which the synced level disagrees with the accepted level. A press pulse
  // is emitted only when a low level is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_stable <= '1;
      r_press  <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_key_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_stable[i] <= r_sync2[i];
            r_press[i]  <= ~r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
            r_press[i]  <= 1'b0;
          end
        end else begin
          r_db_cnt[i] <= '0;
          r_press[i]  <= 1'b0;
        end
      end
    end
  end

`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
  // Mask keeps a resume from halting again on the PC it stopped at.
  logic r_bp_mask;
  assign w_bp_hit = bus.sw_break_en && (bus.pc_addr == bus.break_addr) &&
                    (r_state == ST_RUN) && !r_bp_mask;
`else
  logic w_unused_bp;
  assign w_bp_hit    = 1'b0;
  assign w_unused_bp = bus.sw_break_en ^ (^bus.break_addr) ^ (^bus.pc_addr);
`endif

  // Zero-latency enable so a breakpoint hit blocks the instruction at
  // break_addr in the same cycle.
  always_comb begin
    w_clk_en = 1'b0;
    case (r_state)
      ST_RESET: w_clk_en = 1'b1;
      ST_HALT:  w_clk_en = 1'b0;
      ST_RUN:   w_clk_en = !w_bp_hit;
      ST_STEP:  w_clk_en = 1'b1;
      default:  w_clk_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RESET;
      r_rst_cnt   <= '0;
      r_core_rst  <= 1'b1;
      r_cycle_cnt <= '0;
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
      r_bp_mask   <= 1'b0;
`endif
    end else begin
      if (w_press_rst)
        r_cycle_cnt <= '0;
      else if (w_clk_en && (r_state != ST_RESET))
        r_cycle_cnt <= r_cycle_cnt + 32'd1;

`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
      // The first RUN cycle is always enabled, so the mask drops after it;
      // the HALT->RUN branch below re-arms it on entry.
      if (r_state == ST_RUN) r_bp_mask <= 1'b0;
`endif

      if (w_press_rst) begin
        r_state    <= ST_RESET;
        r_rst_cnt  <= '0;
        r_core_rst <= 1'b1;
      end else begin
        case (r_state)
          ST_RESET: begin
            if (r_rst_cnt == RST_LAST) begin
              r_state    <= ST_HALT;
              r_core_rst <= 1'b0;
            end else begin
              r_rst_cnt <= r_rst_cnt + 8'd1;
            end
          end
          ST_HALT: begin
            if (w_press_run) begin
              r_state <= ST_RUN;
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
              r_bp_mask <= 1'b1;
`endif
            end else if (w_press_step) begin
              r_state <= ST_STEP;
            end
          end
          ST_RUN:   if (w_press_run || w_bp_hit) r_state <= ST_HALT;
          ST_STEP:  r_state <= ST_HALT;
          default:  r_state <= ST_RESET;
        endcase
      end
    end
  end

  assign bus.core_clk_en = w_clk_en;
  assign bus.core_rst    = r_core_rst;
  assign bus.ctrl_state  = r_state;
  assign bus.cycle_cnt   = r_cycle_cnt;

endmodule
